// File: rtl/l2_dc_responder_pkg.sv
// Shared encodings and widths for the L2 D-cache responder.
// Holds FSM states, read/write codes and line geometry.
package l2_dc_responder_pkg;

  localparam int LINE_ADDR_W = 28;
  localparam int WORD_W      = 32;
  localparam int LINE_WORDS  = 4;
  localparam int LINE_W      = WORD_W * LINE_WORDS;

  localparam logic L2_RW_READ  = 1'b0;
  localparam logic L2_RW_WRITE = 1'b1;

  typedef enum logic [1:0] {
    L2R_IDLE = 2'd0,
    L2R_RD   = 2'd1,
    L2R_WB   = 2'd2,
    L2R_RESP = 2'd3
  } l2r_state_e;

endpackage

// File: rtl/l2_dc_responder.sv
// L2-side responder: refills or writes back one 128-bit line
// over a 32-bit word-serial memory port, word 0 first.
module l2_dc_responder
  import l2_dc_responder_pkg::*;
#(
  parameter int LINE_ADDR_W = 28,
  parameter int WORD_W      = 32
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     drq,
  input  logic                     l2_cache_rw,
  input  logic [LINE_ADDR_W-1:0]   l2_addr,
  input  logic [WORD_W*4-1:0]      rd_to_l2,
  output logic                     l2_rdy,
  output logic                     dc_en,
  output logic [WORD_W*4-1:0]      data_wd_l2,
  output logic                     mem_wr_dc_en,
  output logic                     r_complete_dc,
  output logic                     l2_complete_w,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [LINE_ADDR_W+1:0]   mem_addr,
  output logic [WORD_W-1:0]        mem_wdata,
  input  logic [WORD_W-1:0]        mem_rdata,
  input  logic                     mem_ack
);

  localparam int LW = WORD_W * LINE_WORDS;

  l2r_state_e             state_q, state_d;
  logic [LINE_ADDR_W-1:0] addr_q, addr_d;
  logic                   rw_q, rw_d;
  logic [LW-1:0]          line_q, line_d;
  logic [LW-1:0]          data_q, data_d;
  logic [1:0]             beat_q, beat_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= L2R_IDLE;
      addr_q  <= '0;
      rw_q    <= L2_RW_READ;
      line_q  <= '0;
      data_q  <= '0;
      beat_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rw_q    <= rw_d;
      line_q  <= line_d;
      data_q  <= data_d;
      beat_q  <= beat_d;
    end
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rw_d    = rw_q;
    line_d  = line_q;
    data_d  = data_q;
    beat_d  = beat_q;
    unique case (state_q)
      L2R_IDLE: begin
        if (drq) begin
          addr_d  = l2_addr;
          rw_d    = l2_cache_rw;
          line_d  = rd_to_l2;
          beat_d  = '0;
          state_d = (l2_cache_rw == L2_RW_WRITE)
                    ? L2R_WB : L2R_RD;
        end
      end
      L2R_RD, L2R_WB: begin
        if (mem_ack) begin
          if (state_q == L2R_RD)
            line_d[WORD_W*beat_q +: WORD_W] = mem_rdata;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) begin
            state_d = L2R_RESP;
            // refill output updates only as the last word lands
            if (state_q == L2R_RD)
              data_d = line_d;
          end
        end
      end
      L2R_RESP: state_d = L2R_IDLE;
      default:  state_d = L2R_IDLE;
    endcase
  end

  assign l2_rdy        = (state_q == L2R_IDLE);
  assign dc_en         = ~l2_rdy;
  assign mem_req       = (state_q == L2R_RD)
                       | (state_q == L2R_WB);
  assign mem_we        = (state_q == L2R_WB);
  assign mem_addr      = {addr_q, beat_q};
  assign mem_wdata     = line_q[WORD_W*beat_q +: WORD_W];
  assign data_wd_l2    = data_q;
  assign mem_wr_dc_en  = (state_q == L2R_RESP)
                       & (rw_q == L2_RW_READ);
  assign r_complete_dc = mem_wr_dc_en;
  assign l2_complete_w = (state_q == L2R_RESP)
                       & (rw_q == L2_RW_WRITE);

endmodule
